// File: rtl/game_state_ctrl.sv
// game_state_ctrl
// Game sequencer: menu -> countdown -> play -> (grace) -> won/lost -> menu.
// Drives the obstacle counter controls and tracks lives and level.
//
// Optional feature macro: GAME_LIVES_EN
//   defined   : multi-life play with a post-hit GRACE phase and reset_obj_count pulse
//   undefined : any collision in PLAY loses, lives tied to 1, reset_obj_count tied to 0
//
// Ports:
//   clk              system clock
//   reset            asynchronous, active-high reset
//   start_btn        synchronised start button level (rising edge is the event)
//   collision        player/obstacle overlap level
//   game_time[10:0]  elapsed play time from the counter
//   menuScreen       holds the counter at zero (MENU or COUNTDOWN)
//   playerWon        WON phase
//   playerLost       LOST phase
//   reset_obj_count  one-cycle pulse restarting obstacle position after a hit
//   countdown_active high in COUNTDOWN
//   lives[1:0]       remaining lives
//   level[1:0]       current level 0..3
module game_state_ctrl #(
   parameter logic [10:0] WIN_TIME        = 11'd1800,
   parameter logic [7:0]  COUNTDOWN_TICKS = 8'd120,
   parameter logic [7:0]  GRACE_TICKS     = 8'd60,
   parameter logic [7:0]  RESULT_TICKS    = 8'd180,
   parameter logic [1:0]  START_LIVES     = 2'd3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_btn,
   input  logic        collision,
   input  logic [10:0] game_time,
   output logic        menuScreen,
   output logic        playerWon,
   output logic        playerLost,
   output logic        reset_obj_count,
   output logic        countdown_active,
   output logic [1:0]  lives,
   output logic [1:0]  level
);

   typedef enum logic [2:0] {
      MENU      = 3'd0,
      COUNTDOWN = 3'd1,
      PLAY      = 3'd2,
      GRACE     = 3'd3,
      WON       = 3'd4,
      LOST      = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] tick_q, tick_d;
   logic [1:0] level_q, level_d;
   logic       start_q;
   logic       start_edge;
   logic       win;

   assign start_edge = start_btn & ~start_q;
   assign win        = (game_time >= WIN_TIME);

`ifdef GAME_LIVES_EN
   logic [1:0] lives_q, lives_d;
   logic       roc_q, roc_d;
`endif

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= MENU;
         tick_q  <= 8'd0;
         level_q <= 2'd0;
         start_q <= 1'b0;
`ifdef GAME_LIVES_EN
         lives_q <= START_LIVES;
         roc_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         level_q <= level_d;
         start_q <= start_btn;
`ifdef GAME_LIVES_EN
         lives_q <= lives_d;
         roc_q   <= roc_d;
`endif
      end
   end

   // Next-state and entry actions; counters reload on entry to the state that uses them
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      level_d = level_q;
`ifdef GAME_LIVES_EN
      lives_d = lives_q;
      roc_d   = 1'b0;
`endif
      case (state_q)
         MENU: begin
            if (start_edge) begin
               state_d = COUNTDOWN;
               tick_d  = COUNTDOWN_TICKS - 8'd1;
`ifdef GAME_LIVES_EN
               lives_d = START_LIVES;
`endif
            end
         end
         COUNTDOWN: begin
            if (tick_q == 8'd0) state_d = PLAY;
            else                tick_d  = tick_q - 8'd1;
         end
         PLAY: begin
            // Collision outranks a simultaneous win
            if (collision) begin
`ifdef GAME_LIVES_EN
               if (lives_q > 2'd1) begin
                  state_d = GRACE;
                  lives_d = lives_q - 2'd1;
                  roc_d   = 1'b1;
                  tick_d  = GRACE_TICKS - 8'd1;
               end else begin
                  state_d = LOST;
                  lives_d = 2'd0;
                  level_d = 2'd0;
                  tick_d  = RESULT_TICKS - 8'd1;
               end
`else
               state_d = LOST;
               level_d = 2'd0;
               tick_d  = RESULT_TICKS - 8'd1;
`endif
            end else if (win) begin
               state_d = WON;
               level_d = (level_q == 2'd3) ? 2'd3 : level_q + 2'd1;
               tick_d  = RESULT_TICKS - 8'd1;
            end
         end
         GRACE: begin
            // Collision ignored; a win outranks grace expiry
            if (win) begin
               state_d = WON;
               level_d = (level_q == 2'd3) ? 2'd3 : level_q + 2'd1;
               tick_d  = RESULT_TICKS - 8'd1;
            end else if (tick_q == 8'd0) begin
               state_d = PLAY;
            end else begin
               tick_d = tick_q - 8'd1;
            end
         end
         WON, LOST: begin
            if (start_edge || tick_q == 8'd0) state_d = MENU;
            else                              tick_d  = tick_q - 8'd1;
         end
         default: state_d = MENU;
      endcase
   end

   // Moore output decode
   always_comb begin
      menuScreen       = 1'b0;
      playerWon        = 1'b0;
      playerLost       = 1'b0;
      countdown_active = 1'b0;
      case (state_q)
         MENU:      menuScreen = 1'b1;
         COUNTDOWN: begin
            menuScreen       = 1'b1;
            countdown_active = 1'b1;
         end
         WON:       playerWon  = 1'b1;
         LOST:      playerLost = 1'b1;
         default:   ;
      endcase
   end

   assign level = level_q;
`ifdef GAME_LIVES_EN
   assign lives           = lives_q;
   assign reset_obj_count = roc_q;
`else
   assign lives           = 2'd1;
   assign reset_obj_count = 1'b0;
`endif

endmodule

// File: tb/tb_game_state_ctrl.sv
module tb_game_state_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_btn;
   logic        collision;
   logic [10:0] game_time;
   logic        menuScreen, playerWon, playerLost, reset_obj_count, countdown_active;
   logic [1:0]  lives, level;

   int n_checks = 0;
   int n_errors = 0;

`ifdef GAME_LIVES_EN
   localparam logic [1:0] LIVES_INIT = 2'd3;
`else
   localparam logic [1:0] LIVES_INIT = 2'd1;
`endif

   game_state_ctrl #(
      .WIN_TIME(11'd1800),
      .COUNTDOWN_TICKS(8'd4),
      .GRACE_TICKS(8'd3),
      .RESULT_TICKS(8'd180),
      .START_LIVES(2'd3)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start_btn(start_btn),
      .collision(collision),
      .game_time(game_time),
      .menuScreen(menuScreen),
      .playerWon(playerWon),
      .playerLost(playerLost),
      .reset_obj_count(reset_obj_count),
      .countdown_active(countdown_active),
      .lives(lives),
      .level(level)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit after the last one
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // From MENU with start_btn low: start, count down, win; leaves the DUT in WON
   task automatic run_to_win(input logic [1:0] lvl);
      start_btn = 1'b1;
      step(1);
      check_val("rw_cd", countdown_active, 1);
      start_btn = 1'b0;
      step(4);
      check_val("rw_play", menuScreen, 0);
      game_time = 11'd1800;
      step(1);
      check_val("rw_won", playerWon, 1);
      check_val("rw_level", level, lvl);
      game_time = 11'd0;
   endtask

   // Leave WON/LOST through a fresh press
   task automatic press_exit();
      start_btn = 1'b1;
      step(1);
      check_val("px_menu", menuScreen, 1);
      check_val("px_won", playerWon, 0);
      check_val("px_lost", playerLost, 0);
      start_btn = 1'b0;
      step(1);
   endtask

   initial begin
      reset = 1'b1;
      start_btn = 1'b0;
      collision = 1'b0;
      game_time = 11'd0;
      #3;
      check_val("rst_menu", menuScreen, 1);
      check_val("rst_won", playerWon, 0);
      check_val("rst_lost", playerLost, 0);
      check_val("rst_roc", reset_obj_count, 0);
      check_val("rst_cd", countdown_active, 0);
      check_val("rst_lives", lives, LIVES_INIT);
      check_val("rst_level", level, 0);
      @(negedge clk);
      reset = 1'b0;
      step(4);
      check_val("idle_menu", menuScreen, 1);

      // Countdown lasts exactly 4 cycles; start stays held (no second edge)
      start_btn = 1'b1;
      step(1);
      check_val("cd_first", countdown_active, 1);
      check_val("cd_lives", lives, LIVES_INIT);
      step(3);
      check_val("cd_last", countdown_active, 1);
      check_val("cd_last_menu", menuScreen, 1);
      step(1);
      check_val("play_cd", countdown_active, 0);
      check_val("play_menu", menuScreen, 0);

`ifdef GAME_LIVES_EN
      // Hit with 3 lives -> GRACE; collision held through grace is ignored
      collision = 1'b1;
      step(1);
      check_val("hit1_lives", lives, 2);
      check_val("hit1_roc", reset_obj_count, 1);
      check_val("hit1_lost", playerLost, 0);
      step(1);
      check_val("gr_roc_low", reset_obj_count, 0);
      check_val("gr_lives", lives, 2);
      step(2);
      check_val("gr_end_lives", lives, 2);
      check_val("gr_end_roc", reset_obj_count, 0);
      step(1);
      check_val("hit2_lives", lives, 1);
      check_val("hit2_roc", reset_obj_count, 1);
      collision = 1'b0;
      step(3);
      check_val("hit2_back", playerLost, 0);
      // Last life: collision together with win time -> LOST
      collision = 1'b1;
      game_time = 11'd1800;
      step(1);
      check_val("last_lost", playerLost, 1);
      check_val("last_won", playerWon, 0);
      check_val("last_lives", lives, 0);
      check_val("last_level", level, 0);
`else
      // Any collision loses, and outranks a simultaneous win
      collision = 1'b1;
      game_time = 11'd1800;
      step(1);
      check_val("hit_lost", playerLost, 1);
      check_val("hit_won", playerWon, 0);
      check_val("hit_lives", lives, 1);
      check_val("hit_roc", reset_obj_count, 0);
`endif
      collision = 1'b0;
      game_time = 11'd0;

      // Fresh press leaves LOST; holding the button does not restart
      start_btn = 1'b0;
      step(1);
      start_btn = 1'b1;
      step(1);
      check_val("lost_exit_menu", menuScreen, 1);
      check_val("lost_exit_cd", countdown_active, 0);
      step(3);
      check_val("held_no_start", countdown_active, 0);
      start_btn = 1'b0;
      step(1);

      // Win to level 1, exit with a press at result cycle 10
      run_to_win(2'd1);
      step(9);
      check_val("won_c10", playerWon, 1);
      press_exit();
      check_val("after_exit_cd", countdown_active, 0);

      run_to_win(2'd2);
      press_exit();
      run_to_win(2'd3);
      press_exit();

      // Level saturates; WON lasts exactly 180 cycles without a press
      run_to_win(2'd3);
      step(179);
      check_val("won_hold", playerWon, 1);
      step(1);
      check_val("won_timeout_menu", menuScreen, 1);
      check_val("won_timeout_won", playerWon, 0);
      check_val("won_timeout_cd", countdown_active, 0);
      check_val("won_level_sat", level, 3);

      // Asynchronous reset mid-game
      start_btn = 1'b1;
      step(1);
      start_btn = 1'b0;
      step(4);
      check_val("pre_rst_play", menuScreen, 0);
`ifdef GAME_LIVES_EN
      collision = 1'b1;
      step(1);
      check_val("pre_rst_roc", reset_obj_count, 1);
      check_val("pre_rst_lives", lives, 2);
`endif
      #2;
      reset = 1'b1;
      #1;
      check_val("mid_rst_menu", menuScreen, 1);
      check_val("mid_rst_lives", lives, LIVES_INIT);
      check_val("mid_rst_roc", reset_obj_count, 0);
      check_val("mid_rst_level", level, 0);
      collision = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      step(2);
      check_val("post_rst_menu", menuScreen, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/game_state_ctrl.md
# game_state_ctrl

Top-level game sequencer that drives the obstacle counter's control inputs (`menuScreen`, `playerWon`, `playerLost`, `reset_obj_count`).
- Runs a Moore FSM through menu, countdown, play, post-hit grace and result phases.
- Tracks lives and level.
- Reads `game_time` and collision back from the datapath.
- Sits between the button/collision logic and the obstacle position/time counter; all on one clock.

## Interface
Parameters:
- `WIN_TIME`, 11'd1800: `game_time` value at or above which play is won.
- `COUNTDOWN_TICKS`, 8'd120: cycles spent in COUNTDOWN (≥1).
- `GRACE_TICKS`, 8'd60: cycles spent in GRACE after a non-fatal hit (≥1).
- `RESULT_TICKS`, 8'd180: cycles WON/LOST are held before auto-return to MENU (≥1).
- `START_LIVES`, 2'd3: lives loaded on entering COUNTDOWN (≥1).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `start_btn` in 1: start button level, already synchronised; rising edge is the event.
- `collision` in 1: player/obstacle overlap, level, valid each cycle.
- `game_time` in 11: elapsed play time from the counter.
- `menuScreen` out 1: holds the counter at zero.
- `playerWon` out 1: WON phase.
- `playerLost` out 1: LOST phase.
- `reset_obj_count` out 1: one-cycle pulse restarting obstacle position.
- `countdown_active` out 1: high in COUNTDOWN.
- `lives` out 2: remaining lives.
- `level` out 2: current level, 0..3.

## Operation
- States: MENU, COUNTDOWN, PLAY, GRACE, WON, LOST.
- Output decode from the state register:
  - `menuScreen` = MENU | COUNTDOWN.
  - `playerWon` = WON.
  - `playerLost` = LOST.
  - `countdown_active` = COUNTDOWN.
- `start_edge` = `start_btn` & ~`start_q`, where `start_q` is `start_btn` registered.
- MENU:
  - `start_edge` → COUNTDOWN.
  - On entry to COUNTDOWN: load `lives` = START_LIVES and tick counter = COUNTDOWN_TICKS-1.
- COUNTDOWN: tick counter decrements each cycle; at 0 → PLAY. `collision` and `start_edge` are ignored.
- PLAY:
  - If `collision`, `lives` == 1 → LOST; `lives` becomes 0.
  - If `collision`, `lives` > 1 → GRACE; `lives` decrements, `reset_obj_count` pulses, tick counter = GRACE_TICKS-1.
  - Else if `game_time` ≥ WIN_TIME → WON.
  - Collision has priority over win in the same cycle.
- GRACE:
  - `collision` is ignored.
  - `game_time` ≥ WIN_TIME → WON, taking priority over tick expiry.
  - Tick counter at 0 → PLAY.
- WON:
  - On entry: `level` increments, saturating at 3; tick counter = RESULT_TICKS-1.
  - `start_edge` or tick counter at 0 → MENU.
- LOST:
  - On entry: `level` = 0; tick counter = RESULT_TICKS-1.
  - Exit conditions as in WON.
- Tick counter: one shared 8-bit down-counter, reloaded on every state entry that uses it.
- `lives` holds in MENU and is reloaded only on COUNTDOWN entry.
- `reset_obj_count` is registered and high for exactly the cycle after the hit edge.

## Timing
Reset values:
- state MENU, so `menuScreen`=1.
- `playerWon`=0, `playerLost`=0, `reset_obj_count`=0, `countdown_active`=0.
- `lives`=START_LIVES, `level`=0, `start_q`=0, tick counter=0.

Latency and durations:
- Input sampled at edge N → new state and its decoded outputs are visible after edge N; latency is one edge.
- COUNTDOWN, GRACE and result phases last exactly their `*_TICKS` cycles when uninterrupted.
- `start_btn` held high across a state change produces no second edge.
- A press during WON/LOST returns to MENU. Starting again needs a new rising edge.

Reset mid-operation: asynchronous return to the reset values in every state; the counter's outputs fall to 0 via `menuScreen`.

## Configuration
- `GAME_LIVES_EN` defined: lives behaviour as above.
- Undefined:
  - Any `collision` in PLAY → LOST.
  - GRACE is unreachable.
  - `lives` is tied to 2'd1.
  - `reset_obj_count` is tied to 0.

## Test plan
- Reset, then `start_btn` 0→1 at cycle 5 (COUNTDOWN_TICKS=4) → `countdown_active`=1 for cycles 6–9, PLAY at cycle 10, `menuScreen` 0 from cycle 10.
- PLAY, `lives`=3, `collision` pulse → GRACE, `lives`=2, `reset_obj_count` high one cycle. A `collision` held for the whole GRACE is ignored, then PLAY resumes.
- PLAY, `lives`=1, `collision` and `game_time`=WIN_TIME in the same cycle → LOST (not WON), `lives`=0, `level`=0.
- `game_time` reaches 1800 from level 3 → WON, `level` stays 3. After RESULT_TICKS=180 cycles with no press → MENU.
- In WON, `start_btn` rising at result cycle 10 → MENU next cycle. `start_btn` held high → stays in MENU until it is released and pressed again.
- Assert `reset` mid-GRACE → immediately MENU, `lives`=3, `reset_obj_count`=0. Repeat the test with `GAME_LIVES_EN` undefined: first collision → LOST.
